// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light front end: FSM state encoding,
// default timing constants and a small sizing helper.
package traffic_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      QUALIFY = 2'b01,
      PRESENT = 2'b10,
      RELEASE = 2'b11
   } sensor_state_e;

   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;
   localparam int unsigned DEFAULT_HOLD_CYCLES     = 3;
   localparam int unsigned DEFAULT_COUNT_W         = 8;
   localparam int unsigned DEFAULT_STUCK_CYCLES    = 1000;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous level inputs; both stages
// clear to 0 on synchronous reset.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/vehicle_sensor_conditioner.sv
// Debounces a raw loop-detector level into a held presence level, an arrival
// pulse and a saturating arrival count. Optional stuck-detector fault is built
// only when VEHICLE_SENSOR_STUCK_DETECT_EN is defined.
module vehicle_sensor_conditioner
   import traffic_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
   parameter int unsigned COUNT_W         = DEFAULT_COUNT_W,
   parameter int unsigned STUCK_CYCLES    = DEFAULT_STUCK_CYCLES
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               raw_in,
   input  logic               count_clr,
   output logic               sensor,
   output logic               detect_pulse,
   output logic [COUNT_W-1:0] vehicle_count,
   output logic               fault
);

   localparam int unsigned CNT_W = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, STUCK_CYCLES)) + 1;

   localparam logic [CNT_W-1:0]   DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
   localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

   sensor_state_e    state;
   logic [CNT_W-1:0] cnt;
   logic             sync;
   logic             fault_next;
   logic             count_inc;
   logic             occupied;

   sync_2ff #(
      .WIDTH(1)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (raw_in),
      .q  (sync)
   );

   // PRESENT and RELEASE share state bit 1, which is the presence level.
   assign occupied  = state[1];
   assign sensor    = occupied & ~fault;
   assign count_inc = detect_pulse & ~fault;

`ifdef VEHICLE_SENSOR_STUCK_DETECT_EN
   localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);
   localparam logic [CNT_W-1:0] STUCK_MAX  = CNT_W'(STUCK_CYCLES);

   logic [CNT_W-1:0] stuck_cnt;
   logic             fault_reg;
   logic             fault_set;

   assign fault_set  = occupied && (stuck_cnt == STUCK_LAST);
   assign fault_next = fault_reg | fault_set;
   assign fault      = fault_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         stuck_cnt <= '0;
         fault_reg <= 1'b0;
      end else begin
         fault_reg <= fault_next;
         if (occupied) begin
            if (stuck_cnt != STUCK_MAX) begin
               stuck_cnt <= stuck_cnt + CNT_ONE;
            end
         end else if (state == IDLE) begin
            stuck_cnt <= '0;
         end
      end
   end
`else
   assign fault_next = 1'b0;
   assign fault      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         detect_pulse  <= 1'b0;
         vehicle_count <= '0;
      end else begin
         detect_pulse <= 1'b0;
         unique case (state)
            IDLE: begin
               if (sync) begin
                  state <= QUALIFY;
                  cnt   <= CNT_ONE;
               end
            end
            QUALIFY: begin
               if (!sync) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == DEB_LAST) begin
                  state        <= PRESENT;
                  cnt          <= '0;
                  detect_pulse <= ~fault_next;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            PRESENT: begin
               if (!sync) begin
                  state <= RELEASE;
                  cnt   <= CNT_ONE;
               end
            end
            RELEASE: begin
               // A returning vehicle resumes presence silently.
               if (sync) begin
                  state <= PRESENT;
                  cnt   <= '0;
               end else if (cnt == HOLD_LAST) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase

         if (count_clr) begin
            vehicle_count <= count_inc ? COUNT_ONE : '0;
         end else if (count_inc && (vehicle_count != COUNT_MAX)) begin
            vehicle_count <= vehicle_count + COUNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Directed plus randomized bench for vehicle_sensor_conditioner against a
// run-length reference model; fault checks follow VEHICLE_SENSOR_STUCK_DETECT_EN.
module tb_vehicle_sensor_conditioner;

   localparam int DEB   = 4;
   localparam int HOLD  = 3;
   localparam int CW    = 2;
   localparam int STUCK = 20;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          raw_in;
   logic          count_clr;
   logic          sensor;
   logic          detect_pulse;
   logic [CW-1:0] vehicle_count;
   logic          fault;

   always #5 clk = ~clk;

   vehicle_sensor_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .HOLD_CYCLES    (HOLD),
      .COUNT_W        (CW),
      .STUCK_CYCLES   (STUCK)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .raw_in       (raw_in),
      .count_clr    (count_clr),
      .sensor       (sensor),
      .detect_pulse (detect_pulse),
      .vehicle_count(vehicle_count),
      .fault        (fault)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: raw delayed two samples, then run-length presence rules.
   bit m_s1, m_s2, m_present, m_pulse, m_fault;
   int m_hi, m_lo, m_stk, m_count;

   function automatic void model_edge();
      bit s;
      bit was_present;
      bit new_pulse;
      bit inc;
      if (rst) begin
         m_s1 = 0; m_s2 = 0; m_present = 0; m_pulse = 0; m_fault = 0;
         m_hi = 0; m_lo = 0; m_stk = 0; m_count = 0;
         return;
      end
      s           = m_s2;
      m_s2        = m_s1;
      m_s1        = raw_in;
      was_present = m_present;
      new_pulse   = 0;
      inc         = m_pulse && !m_fault;
      if (count_clr) m_count = inc ? 1 : 0;
      else if (inc && m_count < CMAX) m_count++;
      if (!m_present) begin
         if (s) begin
            m_hi++;
            if (m_hi == DEB) begin
               m_present = 1; m_hi = 0; m_lo = 0; new_pulse = 1;
            end
         end else m_hi = 0;
      end else begin
         if (!s) begin
            m_lo++;
            if (m_lo == HOLD) begin
               m_present = 0; m_lo = 0; m_hi = 0;
            end
         end else m_lo = 0;
      end
`ifdef VEHICLE_SENSOR_STUCK_DETECT_EN
      if (was_present) begin
         m_stk++;
         if (m_stk == STUCK) m_fault = 1;
      end else m_stk = 0;
`else
      if (was_present) m_stk = 0;
`endif
      m_pulse = new_pulse && !m_fault;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("sensor", 32'(sensor), 32'(m_present && !m_fault));
      chk("detect_pulse", 32'(detect_pulse), 32'(m_pulse));
      chk("vehicle_count", 32'(vehicle_count), 32'(m_count));
      chk("fault", 32'(fault), 32'(m_fault));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst = 1'b1; raw_in = 1'b1; count_clr = 1'b0;

      // Reset held with raw_in high, then release: sensor rises after edge 6.
      run(2);
      chk("t1_rst_sensor", 32'(sensor), 32'd0);
      chk("t1_rst_count", 32'(vehicle_count), 32'd0);
      rst = 1'b0;
      run(5);
      chk("t1_edge5_low", 32'(sensor), 32'd0);
      tick();
      chk("t1_edge6_high", 32'(sensor), 32'd1);
      chk("t1_edge6_pulse", 32'(detect_pulse), 32'd1);
      run(2);

      // Clean arrival and departure.
      raw_in = 1'b0;
      run(10);
      raw_in = 1'b1;
      run(5);
      chk("t2_edge5_low", 32'(sensor), 32'd0);
      tick();
      chk("t2_rise", 32'(sensor), 32'd1);
      chk("t2_pulse", 32'(detect_pulse), 32'd1);
      tick();
      chk("t2_pulse_once", 32'(detect_pulse), 32'd0);
      run(3);
      raw_in = 1'b0;
      run(4);
      chk("t2_fall_edge4", 32'(sensor), 32'd1);
      tick();
      chk("t2_fall_edge5", 32'(sensor), 32'd0);
      run(6);

      // Glitch rejection in both directions.
      raw_in = 1'b1; run(3);
      raw_in = 1'b0; run(10);
      chk("t3_glitch_high", 32'(sensor), 32'd0);
      raw_in = 1'b1; run(12);
      raw_in = 1'b0; run(2);
      raw_in = 1'b1; run(6);
      chk("t3_dropout", 32'(sensor), 32'd1);
      raw_in = 1'b0; run(8);

      // Saturation and clear-on-detect.
      for (int a = 0; a < 5; a++) begin
         raw_in = 1'b1; run(8);
         raw_in = 1'b0; run(8);
      end
      chk("t4_saturate", 32'(vehicle_count), 32'd3);
      raw_in = 1'b1;
      for (int i = 0; i < 20 && !m_pulse; i++) tick();
      chk("t4_pulse_seen", 32'(detect_pulse), 32'd1);
      count_clr = 1'b1;
      tick();
      count_clr = 1'b0;
      chk("t4_clr_on_detect", 32'(vehicle_count), 32'd1);
      run(3);
      raw_in = 1'b0; run(8);

      // Reset mid-QUALIFY and mid-PRESENT.
      raw_in = 1'b1; run(4);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t5_qual_sensor", 32'(sensor), 32'd0);
      chk("t5_qual_count", 32'(vehicle_count), 32'd0);
      run(10);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t5_pres_sensor", 32'(sensor), 32'd0);
      chk("t5_pres_count", 32'(vehicle_count), 32'd0);
      raw_in = 1'b0; run(6);

      // Long presence: stuck fault only with the feature built.
      raw_in = 1'b1; run(30);
`ifdef VEHICLE_SENSOR_STUCK_DETECT_EN
      chk("t6_fault_set", 32'(fault), 32'd1);
      chk("t6_sensor_forced", 32'(sensor), 32'd0);
`else
      chk("t6_no_fault", 32'(fault), 32'd0);
      chk("t6_sensor_held", 32'(sensor), 32'd1);
`endif
      raw_in = 1'b0; run(10);
`ifdef VEHICLE_SENSOR_STUCK_DETECT_EN
      chk("t6_fault_sticky", 32'(fault), 32'd1);
`endif
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t6_fault_cleared", 32'(fault), 32'd0);

      // Randomized segments of raw levels, clears and occasional resets.
      for (int seg = 0; seg < 300; seg++) begin
         int len;
         raw_in = 1'($urandom % 2);
         len = ($urandom % 8 == 0) ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 8));
         for (int i = 0; i < len; i++) begin
            count_clr = ($urandom % 10 == 0);
            rst       = ($urandom % 200 == 0);
            tick();
         end
         rst = 1'b0;
         count_clr = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
